// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_skid_stage
//  Purpose  : Pipeline stage register with a SKID_DEPTH-entry skid FIFO.
//             One registered output slot (d_valid/d_payload) backed by a
//             circular skid buffer that absorbs upstream uops while the
//             downstream stage stalls. Flush discards every held uop.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             flush           - drop all held uops (redirect / trap)
//             u_valid/u_payload/u_stall - upstream valid/stall handshake
//             d_valid/d_payload/d_stall - downstream valid/stall handshake
//             occupancy       - registered skid FIFO entry count
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
  parameter int PAYLOAD_W  = 32,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_W      = $clog2(SKID_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 u_valid,
  input  logic [PAYLOAD_W-1:0] u_payload,
  output logic                 u_stall,
  output logic                 d_valid,
  output logic [PAYLOAD_W-1:0] d_payload,
  input  logic                 d_stall,
  output logic [CNT_W-1:0]     occupancy
);

  localparam int               PTR_W  = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [PTR_W-1:0] c_LAST = PTR_W'(SKID_DEPTH - 1);
  localparam logic [CNT_W-1:0] c_FULL = CNT_W'(SKID_DEPTH);

  logic [PAYLOAD_W-1:0] r_mem [SKID_DEPTH];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_occ;
  logic                 r_d_valid;
  logic [PAYLOAD_W-1:0] r_d_payload;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_accept;
  logic                 w_pop;
  logic                 w_push;
  logic [CNT_W-1:0]     w_occ_nxt;

  // Modulo increment by explicit compare so non-power-of-2 depths wrap right.
  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == c_LAST) ? '0 : p + 1'b1;
  endfunction

  // Stall is a pure function of registered state: no combinational path
  // from u_valid, d_stall or flush.
  assign w_full   = (r_occ == c_FULL);
  assign w_empty  = (r_occ == '0);
  assign w_accept = u_valid & ~w_full;
  assign w_pop    = ~d_stall & ~w_empty;
  // With an empty skid and a moving output, the accepted uop bypasses the
  // FIFO straight into the output register.
  assign w_push   = w_accept & (d_stall | ~w_empty);

  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_nxt = r_occ + 1'b1;
      2'b01:   w_occ_nxt = r_occ - 1'b1;
      default: w_occ_nxt = r_occ;
    endcase
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) r_tail <= f_inc(r_tail);
      if (w_pop)  r_head <= f_inc(r_head);
      r_occ <= w_occ_nxt;
    end
  end

  // Skid storage; contents are only cleared by reset, flush just
  // invalidates them through the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) r_mem[i] <= '0;
    end else if (!flush && w_push) begin
      r_mem[r_tail] <= u_payload;
    end
  end

  // Output register. While stalled it holds whatever it has, including a
  // bubble, so a stalled d_valid=0 is never overwritten.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_d_valid   <= 1'b0;
      r_d_payload <= '0;
    end else if (!d_stall) begin
      if (!w_empty) begin
        r_d_valid   <= 1'b1;
        r_d_payload <= r_mem[r_head];
      end else begin
        r_d_valid   <= w_accept;
        r_d_payload <= u_payload;
      end
    end
  end

  assign u_stall   = w_full;
  assign d_valid   = r_d_valid;
  assign d_payload = r_d_payload;
  assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_skid_stage
//  Purpose  : Self-checking bench for pipe_skid_stage. Two instances
//             (SKID_DEPTH 2 and 3, PAYLOAD_W 8) share one stimulus stream
//             and are compared every cycle against a list-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;

  logic       clk = 1'b0;
  logic       rst, flush, u_valid, d_stall;
  logic [7:0] u_payload;

  logic       d2_valid, d3_valid, u2_stall, u3_stall;
  logic [7:0] d2_payload, d3_payload;
  logic [1:0] d2_occ, d3_occ;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.PAYLOAD_W(8), .SKID_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .u_valid(u_valid), .u_payload(u_payload),
    .u_stall(u2_stall), .d_valid(d2_valid), .d_payload(d2_payload),
    .d_stall(d_stall), .occupancy(d2_occ));

  pipe_skid_stage #(.PAYLOAD_W(8), .SKID_DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .u_valid(u_valid), .u_payload(u_payload),
    .u_stall(u3_stall), .d_valid(d3_valid), .d_payload(d3_payload),
    .d_stall(d_stall), .occupancy(d3_occ));

  // Model: per instance, an ordered list of held uops (index 0 = oldest)
  // plus the visible output slot.
  int         c_depth [2] = '{2, 3};
  logic       m_dv  [2];
  logic [7:0] m_dp  [2];
  logic [7:0] m_buf [2][8];
  int         m_cnt [2];

  // Pointer wrap counter for the depth-3 instance.
  logic       wrap_en = 1'b0;
  int         wraps   = 0;
  logic [1:0] prev_head = '0;
  always @(negedge clk) begin
    if (wrap_en && prev_head == 2'd2 && dut3.r_head == 2'd0) wraps <= wraps + 1;
    prev_head <= dut3.r_head;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic i_r, input logic i_f, input logic i_uv,
                              input logic [7:0] i_up, input logic i_ds);
    logic acc;
    for (int k = 0; k < 2; k++) begin
      acc = i_uv && (m_cnt[k] != c_depth[k]);
      if (i_r || i_f) begin
        m_dv[k] = 1'b0; m_dp[k] = 8'h00; m_cnt[k] = 0;
      end else if (!i_ds) begin
        if (m_cnt[k] > 0) begin
          m_dp[k] = m_buf[k][0];
          m_dv[k] = 1'b1;
          for (int j = 0; j < 7; j++) m_buf[k][j] = m_buf[k][j+1];
          m_cnt[k]--;
          if (acc) begin m_buf[k][m_cnt[k]] = i_up; m_cnt[k]++; end
        end else begin
          m_dp[k] = i_up;
          m_dv[k] = acc;
        end
      end else if (acc) begin
        m_buf[k][m_cnt[k]] = i_up; m_cnt[k]++;
      end
    end
  endtask

  // Apply inputs for one cycle, advance the model, clock, compare.
  task automatic step(input logic i_r, input logic i_f, input logic i_uv,
                      input logic [7:0] i_up, input logic i_ds);
    rst = i_r; flush = i_f; u_valid = i_uv; u_payload = i_up; d_stall = i_ds;
    model_update(i_r, i_f, i_uv, i_up, i_ds);
    @(posedge clk);
    #1;
    check_eq("d2_valid", d2_valid, m_dv[0]);
    if (m_dv[0]) check_eq("d2_payload", d2_payload, m_dp[0]);
    check_eq("d2_occupancy", d2_occ, m_cnt[0]);
    check_eq("d2_u_stall", u2_stall, m_cnt[0] == 2);
    check_eq("d2_occ_bound", d2_occ <= 2'd2, 1);
    check_eq("d3_valid", d3_valid, m_dv[1]);
    if (m_dv[1]) check_eq("d3_payload", d3_payload, m_dp[1]);
    check_eq("d3_occupancy", d3_occ, m_cnt[1]);
    check_eq("d3_u_stall", u3_stall, m_cnt[1] == 3);
    check_eq("d3_occ_bound", d3_occ <= 2'd3, 1);
  endtask

  // Spot check of the depth-2 instance against fixed values.
  task automatic expect2(input string tag, input logic dv, input logic [7:0] dp,
                         input logic [1:0] occ, input logic us);
    check_eq({tag, "_valid"}, d2_valid, dv);
    check_eq({tag, "_payload"}, d2_payload, dp);
    check_eq({tag, "_occ"}, d2_occ, occ);
    check_eq({tag, "_ustall"}, u2_stall, us);
  endtask

  initial begin
    int         acc_n;
    logic       pend;
    logic       uv;
    logic [7:0] up;
    logic       ds;

    for (int k = 0; k < 2; k++) begin
      m_dv[k] = 1'b0; m_dp[k] = 8'h00; m_cnt[k] = 0;
      for (int j = 0; j < 8; j++) m_buf[k][j] = 8'h00;
    end
    rst = 1'b1; flush = 1'b0; u_valid = 1'b0; u_payload = 8'h00; d_stall = 1'b0;

    // Reset
    step(1, 0, 1, 8'hEE, 1);
    step(1, 0, 0, 8'h00, 0);
    expect2("reset", 0, 8'h00, 2'd0, 0);

    // Streaming: 1-cycle latency, no occupancy
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 1, 8'(i), 0);
      expect2("stream", 1, 8'(i), 2'd0, 0);
    end
    step(0, 0, 0, 8'h00, 0);

    // Skid fill / drain
    step(0, 0, 1, 8'hA0, 0); expect2("skid0", 1, 8'hA0, 2'd0, 0);
    step(0, 0, 1, 8'hA1, 1); expect2("skid1", 1, 8'hA0, 2'd1, 0);
    step(0, 0, 1, 8'hA2, 1); expect2("skid2", 1, 8'hA0, 2'd2, 1);
    step(0, 0, 1, 8'hA3, 1); expect2("skid3", 1, 8'hA0, 2'd2, 1);
    step(0, 0, 1, 8'hA3, 0); expect2("drain1", 1, 8'hA1, 2'd1, 0);
    step(0, 0, 1, 8'hA3, 0); expect2("drain2", 1, 8'hA2, 2'd1, 0);
    step(0, 0, 0, 8'h00, 0); expect2("drain3", 1, 8'hA3, 2'd0, 0);
    step(0, 0, 0, 8'h00, 0);
    check_eq("drain_bubble", d2_valid, 0);

    // Flush mid-stall
    step(0, 0, 1, 8'h55, 0);
    step(0, 0, 1, 8'h56, 1);
    step(0, 0, 1, 8'h57, 1); expect2("preflush", 1, 8'h55, 2'd2, 1);
    step(0, 1, 1, 8'h77, 1); expect2("flush", 0, 8'h00, 2'd0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 8'h00, 0);
      check_eq("flush_no_0x77", d2_valid, 0);
    end

    // Held bubble
    step(0, 0, 1, 8'h3C, 1);
    check_eq("bubble_valid", d2_valid, 0);
    check_eq("bubble_occ", d2_occ, 1);
    step(0, 0, 0, 8'h00, 0); expect2("bubble_out", 1, 8'h3C, 2'd0, 0);

    // Reset mid-operation, together with flush and a valid input
    step(0, 0, 1, 8'h11, 0);
    step(0, 0, 1, 8'h12, 1);
    step(0, 0, 1, 8'h13, 1); expect2("prerst", 1, 8'h11, 2'd2, 1);
    step(1, 1, 1, 8'h99, 0); expect2("midrst", 0, 8'h00, 2'd0, 0);
    step(0, 0, 1, 8'h21, 0); expect2("postrst", 1, 8'h21, 2'd0, 0);
    step(0, 0, 0, 8'h00, 0);

    // Randomised traffic; upstream obeys the depth-3 instance's stall.
    wrap_en = 1'b1;
    acc_n   = 0;
    pend    = 1'b0;
    up      = 8'h00;
    for (int cyc = 0; cyc < 5000 && acc_n < 200; cyc++) begin
      if (!pend) begin
        uv = ($urandom_range(0, 3) != 0);
        up = 8'($urandom);
      end else begin
        uv = 1'b1;
      end
      ds = 1'($urandom_range(0, 1));
      if (uv && m_cnt[1] != 3) begin
        acc_n++;
        pend = 1'b0;
      end else begin
        pend = uv;
      end
      step(0, 0, uv, up, ds);
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 8'h00, 0);
    wrap_en = 1'b0;
    check_eq("rand_accepted", acc_n, 200);
    check_eq("rand_drained_occ", d3_occ, 0);
    check_eq("rand_wraps_ge_10", wraps >= 10, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised pipeline stage register for the in-order core: one output register plus a SKID_DEPTH-entry skid FIFO.
- Uses the core's valid/stall handshake on both sides and carries an opaque PAYLOAD_W-bit uop.
- Adds a pipeline flush and an occupancy output.
- Successor to the single-entry stall buffer in the current stage registers; fetch→decode, decode→execute and later stage boundaries instantiate it.

Parameters:
- PAYLOAD_W, 32, width of the uop payload in bits (≥1).
- SKID_DEPTH, 2, skid FIFO entries (≥1); circular buffer, any value legal (not restricted to powers of 2).
- CNT_W, $clog2(SKID_DEPTH+1), width of occupancy (derived; not overridden).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all held uops (branch redirect/trap).
- u_valid  in  1  upstream uop valid.
- u_payload  in  PAYLOAD_W  upstream uop.
- u_stall  out  1  upstream must hold u_valid/u_payload this cycle.
- d_valid  out  1  output uop valid (registered).
- d_payload  out  PAYLOAD_W  output uop (registered).
- d_stall  in  1  downstream did not consume d_payload this cycle.
- occupancy  out  CNT_W  skid FIFO entry count, 0..SKID_DEPTH (registered).

Behaviour:
- Reset (rst high at posedge):
  - d_valid=0, d_payload=0, occupancy=0.
  - FIFO head/tail pointers=0, FIFO contents=0.
  - rst beats flush and all other inputs.
- u_stall = (occupancy == SKID_DEPTH).
  - Combinational from registered state only; no path from u_valid, d_stall or flush.
- accept = u_valid & ~u_stall. An accepted uop is never lost except by flush or rst.
- flush (rst low):
  - Next cycle: d_valid=0, occupancy=0, pointers=0.
  - The uop presented on the flush cycle is dropped, even if accepted.
  - d_payload is don't-care after flush; the implementation clears it to 0.
  - flush with d_stall=1 still clears everything.
- Normal cycle, d_stall=0 (output advances):
  - occupancy>0: d_payload←FIFO head, d_valid←1, pop. If accept, the input is also pushed, so occupancy is unchanged.
  - occupancy==0: d_payload←u_payload, d_valid←accept. Bubbles propagate as d_valid=0.
- Normal cycle, d_stall=1 (output holds):
  - d_valid and d_payload keep their values. This includes d_valid=0 — a bubble is held, not overwritten.
  - If accept: push u_payload, occupancy+1.
- Ordering: strict FIFO. Output order equals acceptance order.
- Latency:
  - 1 cycle u→d when the FIFO is empty and d_stall=0.
  - Otherwise 1 + (entries ahead) cycles of d_stall=0.
- Full boundary:
  - At occupancy==SKID_DEPTH, u_stall=1 and no push is possible.
  - A pop on that cycle lowers occupancy, so u_stall deasserts the next cycle (one-cycle bubble on refill; accepted).
- Pointer wrap: head/tail increment modulo SKID_DEPTH (explicit compare, no power-of-2 masking).
- Invariants, checked by assertions in the bench:
  - occupancy ≤ SKID_DEPTH.
  - No push when full; no pop when empty.
  - d_payload/d_valid stable while d_stall=1 and flush=0.
  - u_stall depends only on state.
- Throughput: 1 uop/cycle sustained when d_stall=0.

Test Plan (PAYLOAD_W=8, SKID_DEPTH=2 unless stated):
- Streaming:
  - Stimulus: u_valid=1 with payloads 0x01..0x10 on consecutive cycles, d_stall=0.
  - Response: d_payload 0x01..0x10 exactly one cycle later, d_valid=1 each cycle, occupancy=0, u_stall=0 throughout.
- Skid fill/drain:
  - Stimulus: stream 0xA0,0xA1,0xA2,0xA3; d_stall=1 from the cycle after 0xA0 appears for 3 cycles.
  - Response: d_payload holds 0xA0; occupancy 1→2; u_stall=1 with 0xA3 held upstream.
  - On release: outputs 0xA1,0xA2,0xA3 in order; occupancy returns to 0; no loss or duplication.
- Wrap-around:
  - Stimulus: SKID_DEPTH=3, random d_stall (50%), 200 random payloads.
  - Response: scoreboard output sequence equals input sequence; occupancy never >3; pointers wrap ≥10 times.
- Flush mid-stall:
  - Stimulus: occupancy=2, d_valid=1 (0x55), d_stall=1; assert flush with u_valid=1 (0x77).
  - Response: next cycle d_valid=0, occupancy=0, u_stall=0; 0x77 never appears at the output.
- Held bubble:
  - Stimulus: d_valid=0, d_stall=1, u_valid=1 (0x3C).
  - Response: d_valid stays 0; occupancy=1.
  - After d_stall=0: 0x3C appears one cycle later with d_valid=1.
- Reset mid-operation:
  - Stimulus: occupancy=2 and d_valid=1; assert rst together with flush=1, u_valid=1.
  - Response: d_valid=0, d_payload=0, occupancy=0, u_stall=0 next cycle; first uop after rst deasserts emerges with 1-cycle latency.
